// File: rtl/mem_access_unit_if.sv
// Word-aligned valid/ready data-bus bundle between the memory access unit
// and data memory.
interface mem_access_unit_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_be,
        output bus_we,
        output bus_valid,
        input  bus_ready,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        input  bus_we,
        input  bus_valid,
        output bus_ready,
        output bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Runs one core load/store as a single word-aligned bus transaction and
// returns the extended load data or a fault through a done pulse.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_WE,
    input  logic [2:0]  mem_MODE,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_fault,
    output logic        busy,
    mem_access_unit_if.master bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUS   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [31:0] addr_q;
    logic [2:0]  mode_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        illegal;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;

    always_comb begin
        be_d    = 4'b0000;
        wdata_d = mem_wdata;
        illegal = 1'b0;
        case (mem_MODE)
            3'b000, 3'b100: begin
                be_d    = 4'b0001 << mem_addr[1:0];
                wdata_d = {4{mem_wdata[7:0]}};
                illegal = mem_WE & mem_MODE[2];
            end
            3'b001, 3'b101: begin
                be_d    = 4'b0011 << mem_addr[1:0];
                wdata_d = {2{mem_wdata[15:0]}};
                illegal = mem_addr[0] | (mem_WE & mem_MODE[2]);
            end
            3'b010: begin
                be_d    = 4'b1111;
                illegal = |mem_addr[1:0];
            end
            default: illegal = 1'b1;
        endcase
    end

    // Unsigned modes differ from signed ones only in mode bit 2.
    always_comb begin
        lane_b  = bus.bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h  = bus.bus_rdata[{addr_q[1], 4'b0000} +: 16];
        ld_data = bus.bus_rdata;
        case (mode_q[1:0])
            2'b00:   ld_data = {{24{lane_b[7] & ~mode_q[2]}}, lane_b};
            2'b01:   ld_data = {{16{lane_h[15] & ~mode_q[2]}}, lane_h};
            default: ld_data = bus.bus_rdata;
        endcase
    end

    assign cnt_nxt = cnt + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            addr_q    <= 32'd0;
            mode_q    <= 3'd0;
            we_q      <= 1'b0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            mem_rdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_req) begin
                        addr_q  <= mem_addr;
                        mode_q  <= mem_MODE;
                        we_q    <= mem_WE;
                        wdata_q <= wdata_d;
                        be_q    <= be_d;
                        cnt     <= 8'd0;
                        state   <= illegal ? S_FAULT : S_BUS;
                    end
                end
                S_BUS: begin
                    if (bus.bus_ready) begin
                        if (!we_q) mem_rdata <= ld_data;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == TMO) state <= S_FAULT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign mem_done  = (state == S_DONE) || (state == S_FAULT);
    assign mem_fault = (state == S_FAULT);

    assign bus.bus_valid = (state == S_BUS);
    assign bus.bus_we    = we_q & (state == S_BUS);
    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses, a bus responder,
// and monitors for bus beats and done pulses.
module tb_mem_access_unit;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic        chk_wdata;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_WE = 1'b0;
    logic [2:0]  mem_MODE = 3'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_fault;
    logic        busy;

    mem_access_unit_if bif ();

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_WE    (mem_WE),
        .mem_MODE  (mem_MODE),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_fault (mem_fault),
        .busy      (busy),
        .bus       (bif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    int ready_delay = 0;
    logic [31:0] rd_word = 32'd0;
    int vcnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        bif.bus_ready = 1'b0;
        bif.bus_rdata = 32'd0;
    end

    // Bus responder; checks the beat on the first valid cycle.
    always @(negedge clk) begin
        if (bif.bus_valid) begin
            if (vcnt == 0) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus_valid", 32'd1, 32'd0);
                end else begin
                    bus_exp_t e;
                    e = bus_q.pop_front();
                    chk("bus_addr", bif.bus_addr, e.addr);
                    chk("bus_be", {28'd0, bif.bus_be}, {28'd0, e.be});
                    chk("bus_we", {31'd0, bif.bus_we}, {31'd0, e.we});
                    if (e.chk_wdata)
                        chk("bus_wdata", bif.bus_wdata, e.wdata);
                end
            end
            if (ready_delay >= 0 && vcnt == ready_delay) begin
                bif.bus_ready = 1'b1;
                bif.bus_rdata = rd_word;
            end else begin
                bif.bus_ready = 1'b0;
                bif.bus_rdata = 32'h5A5A5A5A;
            end
            vcnt++;
        end else begin
            bif.bus_ready = 1'b0;
            vcnt = 0;
        end
    end

    // Done monitor: every done pulse pops one expected response.
    always @(negedge clk) begin
        if (mem_done) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                done_exp_t d;
                d = done_q.pop_front();
                chk("mem_rdata", mem_rdata, d.rdata);
                chk("mem_fault", {31'd0, mem_fault}, {31'd0, d.fault});
            end
        end else if (mem_fault) begin
            chk("fault_without_done", 32'd1, 32'd0);
        end
    end

    // Latency counts negedges after the sampling edge: 1 = cycle N+1.
    task automatic access(input string name, input logic we,
                          input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd,
                          input int delay, input int exp_lat,
                          input logic has_bus, input bus_exp_t be,
                          input done_exp_t de);
        int lat;
        if (has_bus) bus_q.push_back(be);
        done_q.push_back(de);
        ready_delay = delay;
        rd_word     = rd;
        mem_req     = 1'b1;
        mem_WE      = we;
        mem_MODE    = mode;
        mem_addr    = addr;
        mem_wdata   = wdata;
        @(negedge clk);
        mem_req = 1'b0;
        chk({name, "_valid_n1"}, {31'd0, bif.bus_valid}, {31'd0, has_bus});
        lat = 1;
        while (!mem_done && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_valid_at_done"}, {31'd0, bif.bus_valid}, 32'd0);
        @(negedge clk);
    endtask

    function automatic bus_exp_t mk_bus(input logic [31:0] a,
                                        input logic [3:0] b, input logic w,
                                        input logic c, input logic [31:0] d);
        bus_exp_t e;
        e.addr = a;
        e.be = b;
        e.we = w;
        e.chk_wdata = c;
        e.wdata = d;
        return e;
    endfunction

    function automatic done_exp_t mk_done(input logic [31:0] r,
                                          input logic f);
        done_exp_t d;
        d.rdata = r;
        d.fault = f;
        return d;
    endfunction

    initial begin
        bus_exp_t nb;
        nb = mk_bus(32'd0, 4'd0, 1'b0, 1'b0, 32'd0);
        #12;
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_done", {31'd0, mem_done}, 32'd0);
        chk("rst_fault", {31'd0, mem_fault}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, bif.bus_valid}, 32'd0);
        chk("rst_we", {31'd0, bif.bus_we}, 32'd0);
        chk("rst_be", {28'd0, bif.bus_be}, 32'd0);
        chk("rst_addr", bif.bus_addr, 32'd0);
        chk("rst_wdata", bif.bus_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        access("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 1'b1,
               mk_bus(32'h100, 4'b1111, 1'b0, 1'b0, 32'h0),
               mk_done(32'hDEADBEEF, 1'b0));
        access("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 3, 1'b1,
               mk_bus(32'h100, 4'b1000, 1'b0, 1'b0, 32'h0),
               mk_done(32'hFFFFFF80, 1'b0));
        access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 2, 1'b1,
               mk_bus(32'h100, 4'b1000, 1'b0, 1'b0, 32'h0),
               mk_done(32'h00000080, 1'b0));
        access("sh", 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0, 2,
               1'b1, mk_bus(32'h100, 4'b1100, 1'b1, 1'b1, 32'hABCDABCD),
               mk_done(32'h00000080, 1'b0));
        access("lw_mis", 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 1'b0,
               nb, mk_done(32'h00000080, 1'b1));
        access("sb_m100", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1, 1'b0,
               nb, mk_done(32'h00000080, 1'b1));
        access("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 2, 1'b1,
               mk_bus(32'h100, 4'b1100, 1'b0, 1'b0, 32'h0),
               mk_done(32'hFFFF8001, 1'b0));
        access("lhu", 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F234, 0, 2, 1'b1,
               mk_bus(32'h100, 4'b0011, 1'b0, 1'b0, 32'h0),
               mk_done(32'h0000F234, 1'b0));
        access("m011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 1'b0,
               nb, mk_done(32'h0000F234, 1'b1));
        access("lh_mis", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1, 1'b0,
               nb, mk_done(32'h0000F234, 1'b1));
        access("sw", 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 2, 4, 1'b1,
               mk_bus(32'h104, 4'b1111, 1'b1, 1'b1, 32'hCAFEF00D),
               mk_done(32'h0000F234, 1'b0));
        access("sb", 1'b1, 3'b000, 32'h105, 32'h000000A5, 32'h0, 0, 2, 1'b1,
               mk_bus(32'h104, 4'b0010, 1'b1, 1'b1, 32'hA5A5A5A5),
               mk_done(32'h0000F234, 1'b0));
        // Four valid cycles without ready, then the fault cycle.
        access("tmo", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, -1, 5, 1'b1,
               mk_bus(32'h200, 4'b1111, 1'b0, 1'b0, 32'h0),
               mk_done(32'h0000F234, 1'b1));

        bus_q.push_back(mk_bus(32'h300, 4'b1111, 1'b0, 1'b0, 32'h0));
        ready_delay = -1;
        mem_req  = 1'b1;
        mem_WE   = 1'b0;
        mem_MODE = 3'b010;
        mem_addr = 32'h300;
        @(negedge clk);
        mem_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'd0, bif.bus_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, bif.bus_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_rdata", mem_rdata, 32'd0);
        access("lw_after_rst", 1'b0, 3'b010, 32'h300, 32'h0, 32'h13579BDF,
               0, 2, 1'b1, mk_bus(32'h300, 4'b1111, 1'b0, 1'b0, 32'h0),
               mk_done(32'h13579BDF, 1'b0));

        repeat (3) @(negedge clk);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        chk("done_q_empty", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
